// File: rtl/instruction_cache_dm_pkg.sv
// rtl/instruction_cache_dm_pkg.sv - shared geometry, FSM states and constants for the direct-mapped I-cache
package instruction_cache_dm_pkg;

    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 64;
    localparam int OFF_W      = 2;
    localparam int WORD_W     = $clog2(LINE_WORDS);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = 32 - OFF_W - WORD_W - IDX_W;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_cache_dm_if.sv
// rtl/instruction_cache_dm_if.sv - refill port between the I-cache and main memory port A
interface instruction_cache_dm_if;

    logic [31:0] instruction_memory_address;
    logic        instruction_memory_request;
    logic [31:0] instruction_memory_read_data;
    logic        instruction_memory_ready;

    modport master (
        output instruction_memory_address,
        output instruction_memory_request,
        input  instruction_memory_read_data,
        input  instruction_memory_ready
    );

    modport slave (
        input  instruction_memory_address,
        input  instruction_memory_request,
        output instruction_memory_read_data,
        output instruction_memory_ready
    );

endinterface

// File: rtl/icache_refill_fsm.sv
// rtl/icache_refill_fsm.sv - line refill sequencer: latches the missing line and walks its words
module icache_refill_fsm #(
    parameter int LINE_WORDS = instruction_cache_dm_pkg::LINE_WORDS,
    parameter int WORD_BITS  = $clog2(LINE_WORDS),
    parameter int BASE_BITS  = 30 - WORD_BITS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_miss,
    input  logic [BASE_BITS-1:0]                  i_base,
    input  logic                                  i_ready,
    output instruction_cache_dm_pkg::state_t      o_state,
    output logic [WORD_BITS-1:0]                  o_wcnt,
    output logic [BASE_BITS-1:0]                  o_base,
    output logic                                  o_request,
    output logic [31:0]                           o_address,
    output logic                                  o_wr_en,
    output logic                                  o_fill_done
);
    import instruction_cache_dm_pkg::*;

    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WORD_BITS-1:0]   r_wcnt;
    logic [WORD_BITS-1:0]   w_wcnt_next;
    logic [BASE_BITS-1:0]   r_base;
    logic [BASE_BITS-1:0]   w_base_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wcnt  <= w_wcnt_next;
            r_base  <= w_base_next;
        end
    end

    // Address is built from registers only, so it cannot move while a request waits for ready.
    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_base_next  = r_base;
        o_request    = 1'b0;
        o_wr_en      = 1'b0;
        o_fill_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_miss) begin
                    w_base_next  = i_base;
                    w_wcnt_next  = '0;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                o_request = 1'b1;
                if (i_ready) begin
                    o_wr_en = 1'b1;
                    if (r_wcnt == LAST_WORD) begin
                        o_fill_done  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_wcnt_next  = r_wcnt + WORD_BITS'(1);
                        w_state_next = GAP;
                    end
                end
            end
            GAP: begin
                w_state_next = REQ;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_state   = r_state;
    assign o_wcnt    = r_wcnt;
    assign o_base    = r_base;
    assign o_address = {r_base, r_wcnt, 2'b00};

endmodule

// File: rtl/instruction_cache_dm.sv
// rtl/instruction_cache_dm.sv - direct-mapped read-only L1 instruction cache with same-cycle hits
module instruction_cache_dm #(
    parameter int LINE_WORDS = instruction_cache_dm_pkg::LINE_WORDS,
    parameter int NUM_LINES  = instruction_cache_dm_pkg::NUM_LINES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             i_program_counter_address,
    output logic [31:0]             o_instruction,
    output logic                    o_stall_cpu,
    instruction_cache_dm_if.master  mem
);
    import instruction_cache_dm_pkg::*;

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS  = 32 - OFF_W - WORD_BITS - IDX_BITS;
    localparam int BASE_BITS = TAG_BITS + IDX_BITS;

    logic [29:0]            w_pc_word;
    logic [WORD_BITS-1:0]   w_word;
    logic [IDX_BITS-1:0]    w_idx;
    logic [TAG_BITS-1:0]    w_tag;

    logic [NUM_LINES-1:0]   r_valid;
    logic [TAG_BITS-1:0]    r_tag  [NUM_LINES];
    logic [31:0]            r_data [NUM_LINES][LINE_WORDS];

    state_t                 w_state;
    logic [WORD_BITS-1:0]   w_wcnt;
    logic [BASE_BITS-1:0]   w_base;
    logic                   w_wr_en;
    logic                   w_fill_done;
    logic                   w_request;
    logic [31:0]            w_address;
    logic [IDX_BITS-1:0]    w_fill_idx;
    logic [TAG_BITS-1:0]    w_fill_tag;
    logic                   w_lookup;
    logic                   w_hit;

    // Byte offset bits are dropped here; the rest splits into word, index and tag.
    assign w_pc_word = 30'(i_program_counter_address >> OFF_W);
    assign w_word    = w_pc_word[WORD_BITS-1:0];
    assign w_idx     = w_pc_word[WORD_BITS +: IDX_BITS];
    assign w_tag     = w_pc_word[WORD_BITS+IDX_BITS +: TAG_BITS];

    assign w_fill_idx = w_base[IDX_BITS-1:0];
    assign w_fill_tag = w_base[BASE_BITS-1:IDX_BITS];

    assign w_lookup = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit    = (w_state == IDLE) && w_lookup;

    assign o_stall_cpu   = !w_hit;
    assign o_instruction = w_hit ? r_data[w_idx][w_word] : NOP;

    icache_refill_fsm #(
        .LINE_WORDS (LINE_WORDS),
        .WORD_BITS  (WORD_BITS),
        .BASE_BITS  (BASE_BITS)
    ) u_refill (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_miss      (!w_lookup),
        .i_base      ({w_tag, w_idx}),
        .i_ready     (mem.instruction_memory_ready),
        .o_state     (w_state),
        .o_wcnt      (w_wcnt),
        .o_base      (w_base),
        .o_request   (w_request),
        .o_address   (w_address),
        .o_wr_en     (w_wr_en),
        .o_fill_done (w_fill_done)
    );

    assign mem.instruction_memory_request = w_request;
    assign mem.instruction_memory_address = w_address;

    // The line only becomes valid once its last word lands, so a partial refill never hits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_fill_done) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_data[w_fill_idx][w_wcnt] <= mem.instruction_memory_read_data;
        end
        if (w_fill_done) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

endmodule

// File: tb/tb_instruction_cache_dm.sv
// tb/tb_instruction_cache_dm.sv - directed bench with memory model and refill-address scoreboard
module tb_instruction_cache_dm;
    import instruction_cache_dm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] instr;
    logic        stall;

    instruction_cache_dm_if mem_if ();

    instruction_cache_dm dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .i_program_counter_address (pc),
        .o_instruction             (instr),
        .o_stall_cpu               (stall),
        .mem                       (mem_if)
    );

    always #5 clk = ~clk;

    // Memory model: ready after two edges of a held, stable request; cleared otherwise.
    logic        hold_ready = 1'b0;
    int          m_cnt;
    int          m_n;
    logic        m_ready;
    logic [31:0] m_prev;
    logic [31:0] m_data;

    always_comb begin
        m_n = 0;
        if (mem_if.instruction_memory_request) begin
            if (mem_if.instruction_memory_address == m_prev)
                m_n = (m_cnt < 3) ? m_cnt + 1 : 3;
            else
                m_n = 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_ready <= 1'b0;
            m_prev  <= 32'h0;
            m_data  <= 32'h0;
        end else begin
            m_cnt   <= m_n;
            m_prev  <= mem_if.instruction_memory_address;
            m_ready <= (m_n >= 2) && !hold_ready;
            m_data  <= (mem_if.instruction_memory_address >> 2) * 4 + 32'h1000;
        end
    end

    assign mem_if.instruction_memory_ready     = m_ready;
    assign mem_if.instruction_memory_read_data = m_data;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          hs_count = 0;
    logic        gap_pending = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_fetch(input string tag, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        while (stall !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_stall"}, {31'b0, stall}, 32'd0);
        check(tag, instr, exp);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_if.instruction_memory_request !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, mem_if.instruction_memory_request}, 32'd1);
    endtask

    task automatic wait_hs(input string tag, input int target);
        int n = 0;
        while (hs_count < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(hs_count >= target), 32'd1);
    endtask

    // Refill monitor: pops expected addresses and checks the one-cycle request gap.
    always @(negedge clk) begin
        if (!rst_n) begin
            gap_pending = 1'b0;
            prev_wait   = 1'b0;
        end else begin
            if (gap_pending) begin
                check("gap_request_low", {31'b0, mem_if.instruction_memory_request}, 32'd0);
                gap_pending = 1'b0;
            end
            if (mem_if.instruction_memory_request && prev_wait)
                check("addr_stable", mem_if.instruction_memory_address, prev_addr);
            if (mem_if.instruction_memory_request && mem_if.instruction_memory_ready) begin
                if (exp_q.size() == 0) begin
                    check("refill_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("refill_addr", mem_if.instruction_memory_address, exp_q.pop_front());
                end
                hs_count++;
                gap_pending = 1'b1;
            end
            prev_wait = mem_if.instruction_memory_request && !mem_if.instruction_memory_ready;
            prev_addr = mem_if.instruction_memory_address;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int target;

        // 1: reset state, then cold refill of line 0
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", {31'b0, stall}, 32'd1);
        check("reset_request", {31'b0, mem_if.instruction_memory_request}, 32'd0);
        check("reset_address", mem_if.instruction_memory_address, 32'h0);
        check("reset_instr", instr, NOP);
        @(negedge clk);
        push_line(32'h0, 4);
        rst_n = 1'b1;
        wait_fetch("s1_fetch", 32'h1000);

        // 2: consecutive hits within the line
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            pc = 32'(4 * i);
            #1;
            check("s2_stall", {31'b0, stall}, 32'd0);
            check("s2_instr", instr, 32'h1000 + 32'(4 * i));
            check("s2_request", {31'b0, mem_if.instruction_memory_request}, 32'd0);
        end

        // 3: conflicting tag on index 0 evicts, then the old line misses again
        @(negedge clk);
        pc = 32'h400;
        push_line(32'h400, 4);
        wait_fetch("s3_fetch", 32'h1400);
        @(negedge clk);
        pc = 32'h0;
        #1;
        check("s3_evicted_stall", {31'b0, stall}, 32'd1);
        check("s3_evicted_instr", instr, NOP);
        push_line(32'h0, 4);
        wait_fetch("s3_refetch", 32'h1000);

        // 4: memory holds ready low for 10 cycles
        @(negedge clk);
        hold_ready = 1'b1;
        pc = 32'h10;
        push_line(32'h10, 4);
        wait_req("s4_req_seen");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s4_req_held", {31'b0, mem_if.instruction_memory_request}, 32'd1);
            check("s4_addr_held", mem_if.instruction_memory_address, 32'h10);
            check("s4_stall_held", {31'b0, stall}, 32'd1);
        end
        hold_ready = 1'b0;
        wait_fetch("s4_fetch", 32'h1010);

        // 5: reset after word 1 of a refill
        @(negedge clk);
        pc = 32'h30;
        push_line(32'h30, 2);
        target = hs_count + 2;
        wait_hs("s5_two_words", target);
        wait_req("s5_word2_req");
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_reset_request", {31'b0, mem_if.instruction_memory_request}, 32'd0);
        check("s5_reset_stall", {31'b0, stall}, 32'd1);
        check("s5_reset_address", mem_if.instruction_memory_address, 32'h0);
        @(negedge clk);
        @(negedge clk);
        pc = 32'h0;
        push_line(32'h0, 4);
        rst_n = 1'b1;
        #1;
        check("s5_no_hit_after_reset", {31'b0, stall}, 32'd1);
        wait_fetch("s5_retry_fetch", 32'h1000);
        @(negedge clk);
        pc = 32'h30;
        #1;
        check("s5_partial_invalid", {31'b0, stall}, 32'd1);
        push_line(32'h30, 4);
        wait_fetch("s5_line3_fetch", 32'h1030);

        // 6: PC change mid-refill does not abort the latched line
        @(negedge clk);
        rst_n = 1'b0;
        pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        push_line(32'h0, 4);
        push_line(32'h20, 4);
        rst_n = 1'b1;
        target = hs_count + 1;
        wait_hs("s6_first_word", target);
        pc = 32'h20;
        wait_fetch("s6_fetch", 32'h1020);
        @(negedge clk);
        pc = 32'h0;
        #1;
        check("s6_line0_stall", {31'b0, stall}, 32'd0);
        check("s6_line0_instr", instr, 32'h1000);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
